// File: rtl/uni_stream_decoder_pkg.sv
// Shared types, default sizes and the scale/saturate helper for the unary stream decoder.
package uni_stream_decoder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } decStateT;

    localparam int DEFAULT_WINDOW_LOG2 = 8;
    localparam int DEFAULT_OUT_W       = 8;

    // Arithmetic right shift followed by a clamp into [lo, hi]; unipolar callers pass
    // non-negative raw values, so the shift behaves as a plain logical shift for them.
    function automatic int scaleSat(input int raw, input int shift, input int lo, input int hi);
        int scaled;
        int result;
        scaled = raw >>> shift;
        result = scaled;
        if (scaled > hi) begin
            result = hi;
        end else if (scaled < lo) begin
            result = lo;
        end
        return result;
    endfunction

endpackage

// File: rtl/uni_ones_counter.sv
// Ones/sample counter for one decode window; last flags the sample that closes the window.
module uni_ones_counter
    import uni_stream_decoder_pkg::*;
#(
    parameter int WINDOW_LOG2 = DEFAULT_WINDOW_LOG2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic                   en,
    input  logic                   iBit,
    output logic [WINDOW_LOG2:0]   count,
    output logic                   last
);

    logic [WINDOW_LOG2-1:0] sampleCnt;

    // A load takes sample 0 of a fresh window; the sample counter wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= '0;
            sampleCnt <= '0;
        end else if (load) begin
            count     <= (WINDOW_LOG2+1)'(iBit);
            sampleCnt <= WINDOW_LOG2'(1);
        end else if (en) begin
            count     <= count + (WINDOW_LOG2+1)'(iBit);
            sampleCnt <= sampleCnt + WINDOW_LOG2'(1);
        end
    end

    assign last = (sampleCnt == {WINDOW_LOG2{1'b1}});

endmodule

// File: rtl/uni_stream_decoder.sv
// Decodes a unary bitstream by counting ones over 2^WINDOW_LOG2 cycles, with a valid/ready result.
// Optional feature: define UNI_STREAM_DECODER_BIPOLAR_EN for a bipolar stream and a two's complement oVal.
module uni_stream_decoder
    import uni_stream_decoder_pkg::*;
#(
    parameter int WINDOW_LOG2 = DEFAULT_WINDOW_LOG2,
    parameter int OUT_W       = DEFAULT_OUT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              iBit,
    input  logic              start,
    output logic              busy,
    output logic [OUT_W-1:0]  oVal,
    output logic              oValid,
    input  logic              oReady
);

    localparam int N     = 1 << WINDOW_LOG2;
    localparam int SHIFT = WINDOW_LOG2 - OUT_W;

    decStateT               state;
    decStateT               stateNext;
    logic                   loadCnt;
    logic                   enCnt;
    logic                   latchVal;
    logic                   last;
    logic [WINDOW_LOG2:0]   count;
    logic [WINDOW_LOG2:0]   finalCount;
    logic [OUT_W-1:0]       scaledVal;

    uni_ones_counter #(
        .WINDOW_LOG2 (WINDOW_LOG2)
    ) uCounter (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (loadCnt),
        .en    (enCnt),
        .iBit  (iBit),
        .count (count),
        .last  (last)
    );

    // The result is latched in the same cycle as the final sample, so that sample is added here.
    assign finalCount = count + (WINDOW_LOG2+1)'(iBit);

`ifdef UNI_STREAM_DECODER_BIPOLAR_EN
    assign scaledVal = OUT_W'(scaleSat(int'(finalCount) - N / 2, SHIFT,
                                       -(1 << (OUT_W - 1)), (1 << (OUT_W - 1)) - 1));
`else
    assign scaledVal = OUT_W'(scaleSat(int'(finalCount), SHIFT, 0, (1 << OUT_W) - 1));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // A DONE result is only released by oReady; start alone never overwrites it.
    always_comb begin
        stateNext = state;
        loadCnt   = 1'b0;
        enCnt     = 1'b0;
        latchVal  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    loadCnt   = 1'b1;
                    stateNext = RUN;
                end
            end
            RUN: begin
                enCnt = 1'b1;
                if (last) begin
                    latchVal  = 1'b1;
                    stateNext = DONE;
                end
            end
            DONE: begin
                if (oReady) begin
                    if (start) begin
                        loadCnt   = 1'b1;
                        stateNext = RUN;
                    end else begin
                        stateNext = IDLE;
                    end
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oVal <= '0;
        end else if (latchVal) begin
            oVal <= scaledVal;
        end
    end

    assign busy   = (state == RUN);
    assign oValid = (state == DONE);

endmodule
